// File: rtl/udp_frame_reader_pkg.sv
// Shared AXI read-channel types, constants and FSM encoding for the UDP frame reader.
package udp_frame_reader_pkg;

  localparam int AXI_ADDR_W      = 29;
  localparam int MAX_UDP_PAYLOAD = 1472;

  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef struct packed {
    logic [1:0]            id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic                  valid;
  } axi_ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        valid;
  } axi_r_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_GRANT,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // Burst size limited by the per-burst cap, the words still to fetch and the 4 KB page end.
  function automatic logic [10:0] calc_beats(input logic [11:0] addr_lo,
                                             input logic [10:0] words_left,
                                             input int          max_beats);
    logic [10:0] to_4k;
    logic [10:0] beats;
    to_4k = 11'd1024 - {1'b0, addr_lo[11:2]};
    beats = 11'(max_beats);
    if (words_left < beats) beats = words_left;
    if (to_4k < beats) beats = to_4k;
    return beats;
  endfunction

endpackage

// File: rtl/udp_frame_reader_frame_buf_sdp.sv
// Frame buffer: 32-bit word write port, registered byte-wide read port (1-cycle latency).
module frame_buf_sdp #(
  parameter int DEPTH = 368,
  parameter int WA_W  = 9
) (
  input  logic            clk,
  input  logic            we,
  input  logic [WA_W-1:0] waddr,
  input  logic [31:0]     wdata,
  input  logic [WA_W+1:0] raddr,
  output logic [7:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr[WA_W+1:2]][{raddr[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/udp_frame_reader.sv
// AXI4 read master: fetches one UDP payload from DDR into a local buffer, then streams it as {ctl,byte}.
module udp_frame_reader
  import udp_frame_reader_pkg::*;
#(
  parameter int         ADDR_W      = AXI_ADDR_W,
  parameter int         MAX_BYTES   = MAX_UDP_PAYLOAD,
  parameter int         BURST_BEATS = 16,
  parameter logic [1:0] AXI_ID      = 2'b01
) (
  input  logic              eth_rxck,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [10:0]       byte_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output axi_ar_t           axi_ar,
  input  logic              axi_arready,
  input  axi_r_t            axi_r,
  output logic              axi_rready,
  output logic              tx_req_o,
  input  logic              tx_grant_i,
  output logic [8:0]        txd_o,
  output state_t            dbg_state_o
);

  localparam int          BUF_WORDS = MAX_BYTES / 4;
  localparam int          WA_W      = $clog2(BUF_WORDS);
  localparam int          BA_W      = WA_W + 2;
  localparam logic [10:0] MAX_LEN   = 11'(MAX_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [10:0]       len_q;
  logic [10:0]       words_left_q;
  logic [WA_W-1:0]   wr_idx_q;
  logic [8:0]        burst_beats_q;
  logic [8:0]        beat_cnt_q;
  logic [10:0]       rd_idx_q;
  logic              err_q;
  logic              done_q;
  logic              err_pulse_q;
  logic              done_set;
  logic              err_set;
  logic [10:0]       ar_beats;
  logic              beat_bad;
  logic              buf_we;
  logic [BA_W-1:0]   rd_addr;
  logic [7:0]        buf_rdata;

  assign ar_beats = calc_beats(addr_q[11:0], words_left_q, BURST_BEATS);

  // A beat is bad on an error response, an unexpected last, or when it overruns the burst.
  assign beat_bad = (axi_r.resp != AXI_RESP_OKAY)
                 || (beat_cnt_q >= burst_beats_q)
                 || (axi_r.last && (beat_cnt_q != burst_beats_q - 9'd1));

  assign buf_we = (state_q == ST_RD) && axi_r.valid && !err_q && !beat_bad;

  always_comb begin
    rd_addr = '0;
    if (state_q == ST_STREAM && (rd_idx_q + 11'd1) < len_q) rd_addr = BA_W'(rd_idx_q + 11'd1);
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (byte_len_i == 11'd0)        done_set = 1'b1;
          else if (byte_len_i > MAX_LEN)  err_set  = 1'b1;
          else                            state_d  = ST_AR;
        end
      end
      ST_AR: if (axi_arready) state_d = ST_RD;
      ST_RD: begin
        if (axi_r.valid && axi_r.last) begin
          if (err_q || beat_bad) begin
            state_d = ST_DRAIN;
            err_set = 1'b1;
          end else if (words_left_q != 11'd0) begin
            state_d = ST_AR;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end
      ST_GRANT: if (tx_grant_i) state_d = ST_STREAM;
      ST_STREAM: begin
        if (rd_idx_q == len_q - 11'd1) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge eth_rxck) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      words_left_q  <= '0;
      wr_idx_q      <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      rd_idx_q      <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_set;
      err_pulse_q <= err_set;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q       <= base_addr_i & ~ADDR_W'(3);
            len_q        <= byte_len_i;
            words_left_q <= 11'((12'(byte_len_i) + 12'd3) >> 2);
            wr_idx_q     <= '0;
            err_q        <= 1'b0;
          end
        end
        ST_AR: begin
          if (axi_arready) begin
            addr_q        <= addr_q + ADDR_W'({ar_beats, 2'b00});
            words_left_q  <= words_left_q - ar_beats;
            burst_beats_q <= 9'(ar_beats);
            beat_cnt_q    <= '0;
          end
        end
        ST_RD: begin
          if (axi_r.valid) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (beat_bad) err_q <= 1'b1;
            if (buf_we) wr_idx_q <= wr_idx_q + 1'b1;
          end
        end
        // Byte 0 is addressed while waiting for grant so it is ready on the first stream cycle.
        ST_GRANT:  rd_idx_q <= '0;
        ST_STREAM: rd_idx_q <= rd_idx_q + 11'd1;
        default: ;
      endcase
    end
  end

  // valid/ready: a transfer happens on every rising edge where both valid and ready are high;
  // ar.valid and all AR fields are held stable until that edge, and rready is high only in RD.
  always_comb begin
    axi_ar       = '0;
    axi_ar.id    = AXI_ID;
    axi_ar.addr  = AXI_ADDR_W'(addr_q);
    axi_ar.len   = 8'(ar_beats - 11'd1);
    axi_ar.size  = AXI_SIZE_4B;
    axi_ar.burst = AXI_BURST_INCR;
    axi_ar.lock  = 1'b0;
    axi_ar.cache = AXI_CACHE_DEFAULT;
    axi_ar.prot  = 3'b000;
    axi_ar.qos   = 4'b0000;
    axi_ar.valid = (state_q == ST_AR);
  end

  assign axi_rready  = (state_q == ST_RD);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_pulse_q;
  assign tx_req_o    = (state_q == ST_GRANT) || (state_q == ST_STREAM);
  assign txd_o       = (state_q == ST_STREAM) ? {1'b1, buf_rdata} : 9'h000;
  assign dbg_state_o = state_q;

  frame_buf_sdp #(
    .DEPTH (BUF_WORDS),
    .WA_W  (WA_W)
  ) u_frame_buf (
    .clk   (eth_rxck),
    .we    (buf_we),
    .waddr (wr_idx_q),
    .wdata (axi_r.data),
    .raddr (rd_addr),
    .rdata (buf_rdata)
  );

endmodule

// File: tb/tb_udp_frame_reader.sv
// Bench for udp_frame_reader: AXI read slave over a pattern memory, grant driver and expected-queue scoreboard.
module tb_udp_frame_reader;
  import udp_frame_reader_pkg::*;

  localparam int ADDR_W = AXI_ADDR_W;

  logic              eth_rxck = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [10:0]       byte_len_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  axi_ar_t           axi_ar;
  logic              axi_arready;
  axi_r_t            axi_r;
  logic              axi_rready;
  logic              tx_req_o;
  logic              tx_grant_i;
  logic [8:0]        txd_o;
  state_t            dbg_state_o;

  udp_frame_reader #(
    .ADDR_W      (ADDR_W),
    .MAX_BYTES   (1472),
    .BURST_BEATS (16),
    .AXI_ID      (2'b01)
  ) dut (
    .eth_rxck    (eth_rxck),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .byte_len_i  (byte_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .axi_ar      (axi_ar),
    .axi_arready (axi_arready),
    .axi_r       (axi_r),
    .axi_rready  (axi_rready),
    .tx_req_o    (tx_req_o),
    .tx_grant_i  (tx_grant_i),
    .txd_o       (txd_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #4 eth_rxck = ~eth_rxck;

  // scoreboard state
  int compared   = 0;
  int mismatched = 0;
  logic [36:0] exp_ar_q[$];   // {addr, len}
  logic [9:0]  exp_tx_q[$];   // {first_of_frame, ctl, byte}
  logic [2:0]  exp_evt_q[$];  // {follows_stream, err, done}
  int   cyc           = 0;
  int   last_byte_cyc = 0;
  int   req_cycles    = 0;
  logic prev_ctl      = 1'b0;

  // stimulus knobs
  int err_beat    = -1;
  int burst_no    = 0;
  bit arready_rand = 1'b0;
  bit rgap_rand    = 1'b0;
  int grant_delay  = 3;
  bit grant_pulse  = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return (a[7:0] * 8'd13) ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    return {mem_byte(a + 29'd3), mem_byte(a + 29'd2), mem_byte(a + 29'd1), mem_byte(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI read slave; it also checks each AR handshake against the expected queue
  initial begin : axi_slave
    logic [ADDR_W-1:0] a;
    int n;
    int i;
    bit hs;
    axi_arready = 1'b0;
    axi_r       = '0;
    forever begin
      @(negedge eth_rxck);
      axi_arready = (arready_rand && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      if (!rst && axi_ar.valid && axi_arready) begin
        if (exp_ar_q.size() == 0) begin
          check("unexpected_ar", {axi_ar.addr, axi_ar.len}, 37'h0);
        end else begin
          check("ar_addr_len", {axi_ar.addr, axi_ar.len}, exp_ar_q.pop_front());
        end
        check("ar_const", {axi_ar.id, axi_ar.size, axi_ar.burst, axi_ar.lock, axi_ar.cache,
                           axi_ar.prot, axi_ar.qos},
              {2'b01, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
        a = axi_ar.addr;
        n = int'(axi_ar.len) + 1;
        @(negedge eth_rxck);
        axi_arready = 1'b0;
        i = 0;
        while (i < n && !rst) begin
          if (rgap_rand && $urandom_range(0, 3) == 0) begin
            axi_r = '0;
            hs    = 1'b0;
          end else begin
            axi_r.valid = 1'b1;
            axi_r.data  = word_at(a + 29'(4 * i));
            axi_r.resp  = (burst_no == 0 && i == err_beat) ? 2'b10 : 2'b00;
            axi_r.last  = (i == n - 1);
            hs          = axi_rready;
          end
          @(negedge eth_rxck);
          if (hs) i++;
        end
        axi_r = '0;
        burst_no++;
      end
    end
  end

  // transmit arbiter model
  initial begin : grant_drv
    int req_cnt;
    req_cnt    = 0;
    tx_grant_i = 1'b0;
    forever begin
      @(negedge eth_rxck);
      if (!tx_req_o) begin
        tx_grant_i = 1'b0;
        req_cnt    = 0;
      end else if (tx_grant_i && grant_pulse) begin
        tx_grant_i = 1'b0;
      end else if (!tx_grant_i) begin
        if (req_cnt >= grant_delay) tx_grant_i = 1'b1;
        req_cnt++;
      end
    end
  end

  // output monitor: stream bytes and done/err pulses
  always @(negedge eth_rxck) begin
    cyc++;
    if (tx_req_o) req_cycles++;
    if (txd_o[8]) begin
      if (exp_tx_q.size() == 0) begin
        check("unexpected_byte", 64'(txd_o), 64'h0);
      end else begin
        logic [9:0] e;
        e = exp_tx_q.pop_front();
        check("tx_byte", 64'(txd_o), 64'(e[8:0]));
        if (!e[9]) check("tx_gap", 64'(prev_ctl), 64'h1);
      end
      last_byte_cyc = cyc;
    end else if (txd_o !== 9'h000) begin
      check("txd_idle", 64'(txd_o), 64'h0);
    end
    if (done_o || err_o) begin
      if (exp_evt_q.size() == 0) begin
        check("unexpected_event", {62'h0, err_o, done_o}, 64'h0);
      end else begin
        logic [2:0] ev;
        ev = exp_evt_q.pop_front();
        check("event", {62'h0, err_o, done_o}, 64'(ev[1:0]));
        if (ev[2]) check("done_latency", 64'(cyc - last_byte_cyc), 64'd1);
      end
    end
    prev_ctl = txd_o[8];
  end

  // driver tasks
  task automatic start_req(input logic [ADDR_W-1:0] base, input logic [10:0] len);
    @(negedge eth_rxck);
    burst_no    = 0;
    start_i     = 1'b1;
    base_addr_i = base;
    byte_len_i  = len;
    @(negedge eth_rxck);
    start_i = 1'b0;
  endtask

  task automatic push_bytes(input logic [ADDR_W-1:0] base, input int len);
    logic [ADDR_W-1:0] a0;
    a0 = base & ~29'd3;
    for (int k = 0; k < len; k++) exp_tx_q.push_back({(k == 0), 1'b1, mem_byte(a0 + 29'(k))});
  endtask

  task automatic finish_case(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_evt_q.size() != 0 && n < budget) begin
      @(negedge eth_rxck);
      n++;
    end
    repeat (3) @(negedge eth_rxck);
    check({tag, "_evt_timeout"}, 64'(exp_evt_q.size()), 64'h0);
    check({tag, "_ar_left"}, 64'(exp_ar_q.size()), 64'h0);
    check({tag, "_tx_left"}, 64'(exp_tx_q.size()), 64'h0);
    check({tag, "_busy_end"}, 64'(busy_o), 64'h0);
    exp_evt_q.delete();
    exp_ar_q.delete();
    exp_tx_q.delete();
  endtask

  // main sequence
  initial begin
    int n;
    rst         = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    byte_len_i  = '0;
    repeat (4) @(negedge eth_rxck);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_done_err", {62'h0, done_o, err_o}, 64'h0);
    check("rst_arvalid", 64'(axi_ar.valid), 64'h0);
    check("rst_rready", 64'(axi_rready), 64'h0);
    check("rst_txreq", 64'(tx_req_o), 64'h0);
    check("rst_txd", 64'(txd_o), 64'h0);
    check("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge eth_rxck);

    // single burst; a second start while busy must be ignored
    exp_ar_q.push_back({29'h100, 8'd15});
    push_bytes(29'h100, 64);
    exp_evt_q.push_back(3'b101);
    start_req(29'h100, 11'd64);
    repeat (4) @(negedge eth_rxck);
    check("busy_mid", 64'(busy_o), 64'h1);
    start_req(29'h900, 11'd0);
    finish_case("t1", 400);

    // 4 KB boundary split
    exp_ar_q.push_back({29'hFF8, 8'd1});
    exp_ar_q.push_back({29'h1000, 8'd7});
    push_bytes(29'hFF8, 40);
    exp_evt_q.push_back(3'b101);
    start_req(29'hFF8, 11'd40);
    finish_case("t2", 400);

    // unaligned base, partial final word
    exp_ar_q.push_back({29'h2000, 8'd1});
    push_bytes(29'h2003, 5);
    exp_evt_q.push_back(3'b101);
    grant_delay = 0;
    start_req(29'h2003, 11'd5);
    finish_case("t3", 200);

    // error response on second beat: drained, no stream
    err_beat   = 1;
    req_cycles = 0;
    exp_ar_q.push_back({29'h300, 8'd15});
    exp_evt_q.push_back(3'b010);
    start_req(29'h300, 11'd64);
    finish_case("t4", 400);
    check("err_no_req", 64'(req_cycles), 64'h0);
    err_beat = -1;

    // zero length and over-length
    exp_evt_q.push_back(3'b001);
    start_req(29'h400, 11'd0);
    finish_case("t5", 20);
    exp_evt_q.push_back(3'b010);
    start_req(29'h400, 11'd1500);
    finish_case("t6", 20);
    exp_evt_q.push_back(3'b010);
    start_req(29'h400, 11'd1473);
    finish_case("t6b", 20);

    // reset in the middle of a read burst, then a clean frame
    exp_ar_q.push_back({29'h400, 8'd15});
    start_req(29'h400, 11'd64);
    n = 0;
    while (!axi_rready && n < 100) begin
      @(negedge eth_rxck);
      n++;
    end
    check("rd_reached", 64'(axi_rready), 64'h1);
    repeat (3) @(negedge eth_rxck);
    rst = 1'b1;
    repeat (2) @(negedge eth_rxck);
    check("midrst_busy", 64'(busy_o), 64'h0);
    check("midrst_rready", 64'(axi_rready), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge eth_rxck);
    finish_case("t7a", 5);
    grant_delay = 2;
    exp_ar_q.push_back({29'h500, 8'd1});
    push_bytes(29'h500, 8);
    exp_evt_q.push_back(3'b101);
    start_req(29'h500, 11'd8);
    finish_case("t7", 200);

    // largest payload with AR/R backpressure and a one-cycle grant
    arready_rand = 1'b1;
    rgap_rand    = 1'b1;
    grant_pulse  = 1'b1;
    grant_delay  = 0;
    for (int k = 0; k < 23; k++) exp_ar_q.push_back({29'h7F0 + 29'(64 * k), 8'd15});
    push_bytes(29'h7F0, 1472);
    exp_evt_q.push_back(3'b101);
    start_req(29'h7F0, 11'd1472);
    finish_case("t8", 6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
